lfsr_prbs_tx: RTL and testbench

LFSR_PRBS_TX -- requirements
Module: lfsr_prbs_tx

---
 rtl/lfsr_prbs_tx.sv | 106 ++++++++++
 tb/tb_lfsr_prbs_tx.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_prbs_tx.sv
// PRBS31 (x^31+x^28+1) burst transmitter with valid/ready output and single-beat error injection.
// The LFSR only advances on accepted beats, so the stream is continuous across bursts and stalls.
module lfsr_prbs_tx #(
    parameter int          DATA_WIDTH = 8,
    parameter int          INVERT     = 1,
    parameter logic [30:0] LFSR_INIT  = 31'h7FFFFFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [15:0]           burst_len,
    input  logic                  err_inject,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           beat_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0] INV_MASK = (INVERT != 0) ? {DATA_WIDTH{1'b1}} : '0;

    state_t      state_q, state_d;
    logic [30:0] lfsr_q, lfsr_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] len_q, len_d;
    logic        err_q, err_d;

    logic [30:0]           lfsr_adv;
    logic [DATA_WIDTH-1:0] beat_raw;
    logic                  accept;
    logic                  last_beat;

    // The presented beat is derived from the current LFSR state; lfsr_adv is the
    // state to commit once that beat is accepted. First-generated bit lands in the MSB.
    always_comb begin
        lfsr_adv = lfsr_q;
        beat_raw = '0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            beat_raw[i] = lfsr_adv[30] ^ lfsr_adv[27];
            lfsr_adv    = {lfsr_adv[29:0], beat_raw[i]};
        end
    end

    assign accept    = (state_q == RUN) && m_ready;
    assign last_beat = (len_q != 16'd0) && (cnt_q == len_q - 16'd1);

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        // A pending flag ignores further requests and drops when its beat is taken.
        err_d   = err_q ? ~accept : err_inject;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    len_d   = burst_len;
                end
            end
            RUN: begin
                if (accept) begin
                    lfsr_d = lfsr_adv;
                    cnt_d  = cnt_q + 16'd1;
                end
                if ((accept && last_beat) || stop) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            lfsr_q  <= LFSR_INIT;
            cnt_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    assign m_valid    = (state_q == RUN);
    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign beat_count = cnt_q;
    assign m_data     = m_valid ? (beat_raw ^ INV_MASK ^ DATA_WIDTH'(err_q)) : '0;

endmodule

// File: tb/tb_lfsr_prbs_tx.sv
// Directed bench for lfsr_prbs_tx: hand-derived first beats plus a bit-history PRBS31 reference.
module tb_lfsr_prbs_tx;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic [15:0] burst_len;
    logic        err_inject;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        busy;
    logic        done;
    logic [15:0] beat_count;

    lfsr_prbs_tx #(
        .DATA_WIDTH (8),
        .INVERT     (1),
        .LFSR_INIT  (31'h7FFFFFFF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .burst_len  (burst_len),
        .err_inject (err_inject),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .busy       (busy),
        .done       (done),
        .beat_count (beat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // First eight beats from seed 0x7FFFFFFF, worked out by hand from x[n] = x[n-31]^x[n-28].
    localparam logic [7:0] EXP [8] = '{8'hFF, 8'hFF, 8'hFF, 8'hF1, 8'hFF, 8'hFF, 8'hFF, 8'h03};

    int         n_tests = 0;
    int         n_fail  = 0;
    int         ndiff, diff_idx, bidx, vld_bad;
    logic [7:0] diff_xor;
    bit         hist[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 31; i++) hist.push_back(1'b1);
    endtask

    // hist[0] is x[n-31], hist[3] is x[n-28].
    task automatic model_next(output logic [7:0] b);
        bit fb;
        b = '0;
        for (int k = 0; k < 8; k++) begin
            fb = hist[0] ^ hist[3];
            void'(hist.pop_front());
            hist.push_back(fb);
            b = {b[6:0], fb};
        end
        b = ~b;
    endtask

    task automatic pulse_start(input logic [15:0] len);
        burst_len = len;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic reset_cnts();
        ndiff = 0; diff_idx = -1; bidx = 0; vld_bad = 0; diff_xor = '0;
    endtask

    task automatic step_beat(input logic inj, input logic stp);
        logic [7:0] b;
        m_ready    = 1'b1;
        err_inject = inj;
        stop       = stp;
        model_next(b);
        if (m_valid !== 1'b1) vld_bad++;
        if (m_data !== b) begin
            ndiff++;
            diff_idx = bidx;
            diff_xor = m_data ^ b;
        end
        bidx++;
        tick();
        err_inject = 1'b0;
        stop       = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] b, held;
        int acc, bad, stall_bad, ndone, nbusy;
        bit stalled;

        rst = 1'b1; start = 1'b0; stop = 1'b0; burst_len = '0;
        err_inject = 1'b0; m_ready = 1'b0;
        #1 rst = 1'b0;
        #2;
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", beat_count, 0);
        tick(); tick();
        rst = 1'b1;
        model_reset();

        // Basic 4-beat burst from seed.
        m_ready = 1'b1;
        pulse_start(16'd4);
        chk("b4_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            chk("b4_valid", m_valid, 1);
            chk($sformatf("b4_data%0d", i), m_data, EXP[i]);
            model_next(b);
            tick();
        end
        chk("b4_done", done, 1);
        chk("b4_valid_off", m_valid, 0);
        chk("b4_count", beat_count, 4);
        tick();
        chk("b4_done_end", done, 0);
        chk("b4_count_hold", beat_count, 4);

        // Second burst continues the sequence.
        pulse_start(16'd4);
        for (int i = 4; i < 8; i++) begin
            chk($sformatf("cont_data%0d", i), m_data, EXP[i]);
            model_next(b);
            tick();
        end
        chk("cont_done", done, 1);
        tick();

        // Random backpressure over 1000 beats.
        pulse_start(16'd1000);
        acc = 0; bad = 0; stall_bad = 0; stalled = 0; held = '0;
        for (int cyc = 0; cyc < 5000 && acc < 1000; cyc++) begin
            m_ready = 1'($urandom_range(0, 1));
            if (stalled && m_data !== held) stall_bad++;
            if (m_valid !== 1'b1) bad++;
            if (m_ready) begin
                model_next(b);
                if (m_data !== b) bad++;
                acc++;
                stalled = 0;
            end else begin
                stalled = 1;
                held    = m_data;
            end
            tick();
        end
        m_ready = 1'b1;
        chk("bp_accepted", acc, 1000);
        chk("bp_data_err", bad, 0);
        chk("bp_stall_hold", stall_bad, 0);
        chk("bp_done", done, 1);
        chk("bp_count", beat_count, 1000);
        tick();

        // Error injection in a continuous run, second request while pending ignored, stop on accept.
        pulse_start(16'd0);
        reset_cnts();
        for (int i = 0; i < 5; i++) step_beat(1'b0, 1'b0);
        step_beat(1'b1, 1'b0);
        m_ready = 1'b0; err_inject = 1'b1;
        tick(); tick();
        err_inject = 1'b0;
        for (int i = 0; i < 13; i++) step_beat(1'b0, 1'b0);
        step_beat(1'b0, 1'b1);
        chk("err_ndiff", ndiff, 1);
        chk("err_idx", diff_idx, 6);
        chk("err_xor", diff_xor, 8'h01);
        chk("err_valid", vld_bad, 0);
        chk("stop_done", done, 1);
        chk("stop_count", beat_count, 20);
        tick();

        // Pending error armed in IDLE survives into the next burst.
        err_inject = 1'b1; tick(); err_inject = 1'b0; tick();
        pulse_start(16'd2);
        reset_cnts();
        step_beat(1'b0, 1'b0);
        step_beat(1'b0, 1'b0);
        chk("idle_err_ndiff", ndiff, 1);
        chk("idle_err_idx", diff_idx, 0);
        chk("idle_err_xor", diff_xor, 8'h01);
        chk("idle_err_done", done, 1);
        tick();

        // start coinciding with last-beat acceptance is ignored.
        pulse_start(16'd2);
        reset_cnts();
        step_beat(1'b0, 1'b0);
        model_next(b);
        chk("last_start_data", m_data, b);
        m_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0; nbusy = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) ndone++;
            if (busy) nbusy++;
            tick();
        end
        chk("last_start_ndone", ndone, 1);
        chk("last_start_nbusy", nbusy, 0);
        chk("last_start_count", beat_count, 2);

        // Asynchronous reset mid-burst while stalled.
        m_ready = 1'b0;
        pulse_start(16'd10);
        tick(); tick();
        #3 rst = 1'b0;
        #1;
        chk("arst_valid", m_valid, 0);
        chk("arst_data", m_data, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_count", beat_count, 0);
        tick();
        chk("arst_done_hold", done, 0);
        rst = 1'b1;
        model_reset();
        m_ready = 1'b1;
        pulse_start(16'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("arst_data%0d", i), m_data, EXP[i]);
            model_next(b);
            tick();
        end
        chk("arst_burst_done", done, 1);
        tick();

        // Continuous run through the 16-bit count wrap, then stop on an accepted beat.
        pulse_start(16'd0);
        for (int i = 0; i < 65536; i++) tick();
        chk("wrap_count0", beat_count, 0);
        chk("wrap_busy", busy, 1);
        for (int i = 0; i < 3; i++) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("wrap_done", done, 1);
        chk("wrap_count", beat_count, 4);
        chk("wrap_busy_off", busy, 0);
        tick();
        chk("wrap_done_end", done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
